// File: rtl/eim_pkg.sv
// Shared definitions for the EIM multiply-accumulate slice: FSM encoding,
// default widths and the saturation constant helper.
package eim_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAcc   = 2'd1,
    StFlush = 2'd2,
    StOut   = 2'd3
  } state_e;

  localparam int unsigned EIM_WIDTH = 16;
  localparam int unsigned DEF_ACC_W = 40;
  localparam int unsigned DEF_CNT_W = 16;

  // All-ones value of width w (w <= 64), used as the saturation clamp.
  function automatic logic [63:0] sat_const(input int unsigned w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/eim16x16.sv
// EIM16x16 multiplier stage: purely combinational unsigned product feeding the
// MAC product register.
module eim16x16
  import eim_pkg::*;
#(
  parameter int unsigned W = EIM_WIDTH
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  localparam int unsigned PW = 2 * W;

  assign p = PW'(a) * PW'(b);

endmodule

// File: rtl/eim_mac_accum.sv
// Two-stage multiply-accumulate: product register, then accumulator that sums
// one in_last-delimited vector. Define SATURATE_EN to clamp acc on overflow.
module eim_mac_accum
  import eim_pkg::*;
#(
  parameter int unsigned WIDTH = EIM_WIDTH,
  parameter int unsigned ACC_W = DEF_ACC_W,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  state_e               state_q;
  logic [2*WIDTH-1:0]   prod;
  logic [2*WIDTH-1:0]   p_q;
  logic                 p_vld_q;
  logic                 p_last_q;
  logic [ACC_W-1:0]     acc_q;
  logic [CNT_W-1:0]     count_q;
  logic                 ovf_q;
  logic                 accept;
  logic [ACC_W:0]       sum;
  logic [ACC_W-1:0]     acc_nxt;

  // Handshake signals decode only from registered state.
  assign in_ready  = (state_q == StIdle) || (state_q == StAcc);
  assign out_valid = (state_q == StOut);
  assign accept    = in_valid && in_ready;

  assign out_acc   = acc_q;
  assign out_count = count_q;
  assign out_ovf   = ovf_q;

  eim16x16 #(
    .W (WIDTH)
  ) u_mul (
    .a (in_a),
    .b (in_b),
    .p (prod)
  );

`ifdef SATURATE_EN
  localparam logic [ACC_W-1:0] AccMax = ACC_W'(sat_const(ACC_W));
`endif

  always_comb begin
    sum = {1'b0, acc_q} + {1'b0, ACC_W'(p_q)};
`ifdef SATURATE_EN
    // Once clamped, stay clamped for the rest of the vector.
    acc_nxt = (ovf_q || sum[ACC_W]) ? AccMax : sum[ACC_W-1:0];
`else
    acc_nxt = sum[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      p_q      <= '0;
      p_vld_q  <= 1'b0;
      p_last_q <= 1'b0;
      acc_q    <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      p_vld_q <= accept;
      if (accept) begin
        p_q      <= prod;
        p_last_q <= in_last;
      end

      if (p_vld_q) begin
        acc_q <= acc_nxt;
        ovf_q <= ovf_q | sum[ACC_W];
        if (count_q != '1) count_q <= count_q + CNT_W'(1);
      end

      unique case (state_q)
        StIdle:  if (accept) state_q <= in_last ? StFlush : StAcc;
        StAcc:   if (accept && in_last) state_q <= StFlush;
        StFlush: if (p_vld_q && p_last_q) state_q <= StOut;
        StOut: begin
          // The pipeline is empty in StOut, so clearing here never races an update.
          if (out_ready) begin
            state_q <= StIdle;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_eim_mac_accum.sv
// Directed bench for eim_mac_accum (ACC_W=32); expected overflow value follows
// the SATURATE_EN build.
module tb_eim_mac_accum;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned ACC_W = 32;
  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  int errors = 0;
  int checks = 0;

  eim_mac_accum #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic l);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_last  = l;
  endtask

  logic [31:0] ovf_exp;

  initial begin
`ifdef SATURATE_EN
    ovf_exp = 32'hFFFF_FFFF;
`else
    ovf_exp = 32'hFFFC_0002;
`endif
    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 16'd0, 16'd0, 1'b0);
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_acc", 64'(out_acc), 64'd0);
    check("rst_out_count", 64'(out_count), 64'd0);
    check("rst_out_ovf", 64'(out_ovf), 64'd0);
    rst_n = 1'b1;
    step();
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // 1. single beat
    drive(1'b1, 16'd3, 16'd5, 1'b1);
    step();
    drive(1'b0, 16'd0, 16'd0, 1'b0);
    check("t1_valid_t1", 64'(out_valid), 64'd0);
    check("t1_ready_flush", 64'(in_ready), 64'd0);
    step();
    check("t1_valid_t2", 64'(out_valid), 64'd1);
    check("t1_acc", 64'(out_acc), 64'd15);
    check("t1_count", 64'(out_count), 64'd1);
    check("t1_ovf", 64'(out_ovf), 64'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t1_idle_valid", 64'(out_valid), 64'd0);
    check("t1_idle_ready", 64'(in_ready), 64'd1);

    // 2. streaming, then 3. backpressure with ignored input
    drive(1'b1, 16'd1, 16'd2, 1'b0);
    step();
    drive(1'b1, 16'd3, 16'd4, 1'b0);
    step();
    check("t2_ready_mid", 64'(in_ready), 64'd1);
    drive(1'b1, 16'd5, 16'd6, 1'b0);
    step();
    drive(1'b1, 16'd7, 16'd8, 1'b1);
    step();
    drive(1'b1, 16'd9, 16'd9, 1'b1);
    check("t2_ready_after_last", 64'(in_ready), 64'd0);
    check("t2_valid_t1", 64'(out_valid), 64'd0);
    step();
    check("t2_valid_t2", 64'(out_valid), 64'd1);
    check("t2_acc", 64'(out_acc), 64'd100);
    check("t2_count", 64'(out_count), 64'd4);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_hold_valid", 64'(out_valid), 64'd1);
      check("t3_hold_acc", 64'(out_acc), 64'd100);
      check("t3_hold_count", 64'(out_count), 64'd4);
      check("t3_hold_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    drive(1'b0, 16'd0, 16'd0, 1'b0);
    check("t3_release_valid", 64'(out_valid), 64'd0);
    check("t3_release_ready", 64'(in_ready), 64'd1);
    check("t3_release_acc", 64'(out_acc), 64'd0);
    check("t3_release_count", 64'(out_count), 64'd0);
    step();
    check("t3_no_stray_beat", 64'(in_ready), 64'd1);

    // 6. bubbles
    drive(1'b1, 16'd10, 16'd10, 1'b0);
    step();
    drive(1'b0, 16'd0, 16'd0, 1'b0);
    step();
    drive(1'b1, 16'd20, 16'd20, 1'b1);
    step();
    drive(1'b0, 16'd0, 16'd0, 1'b0);
    step();
    check("t6_valid", 64'(out_valid), 64'd1);
    check("t6_acc", 64'(out_acc), 64'd500);
    check("t6_count", 64'(out_count), 64'd2);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // 4. overflow
    drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
    step();
    drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    step();
    drive(1'b0, 16'd0, 16'd0, 1'b0);
    step();
    check("t4_valid", 64'(out_valid), 64'd1);
    check("t4_acc", 64'(out_acc), 64'(ovf_exp));
    check("t4_ovf", 64'(out_ovf), 64'd1);
    check("t4_count", 64'(out_count), 64'd2);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t4_ovf_cleared", 64'(out_ovf), 64'd0);

    // 5. reset mid-vector
    drive(1'b1, 16'd1, 16'd1, 1'b0);
    step();
    drive(1'b1, 16'd2, 16'd2, 1'b0);
    step();
    drive(1'b0, 16'd0, 16'd0, 1'b0);
    rst_n = 1'b0;
    #2;
    check("t5_rst_valid", 64'(out_valid), 64'd0);
    check("t5_rst_acc", 64'(out_acc), 64'd0);
    check("t5_rst_count", 64'(out_count), 64'd0);
    check("t5_rst_ovf", 64'(out_ovf), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    check("t5_ready", 64'(in_ready), 64'd1);
    drive(1'b1, 16'd2, 16'd2, 1'b1);
    step();
    drive(1'b0, 16'd0, 16'd0, 1'b0);
    step();
    check("t5_valid", 64'(out_valid), 64'd1);
    check("t5_acc", 64'(out_acc), 64'd4);
    check("t5_count", 64'(out_count), 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t5_done", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
